// File: rtl/score_digit_renderer_pkg.sv
// Shared types and constants for the score digit renderer.
//   glyph_code_t  : 4-bit glyph selector (0..9 digits, 10 smiley, 15 blank)
//   GLYPH_SMILEY  : code shown in every cell when the score does not fit
//   GLYPH_BLANK   : code that renders all-zero rows
//   state_t       : load/convert/commit FSM states
//   pow10()       : elaboration-time helper for the overflow threshold
package score_render_pkg;

    typedef logic [3:0] glyph_code_t;

    localparam glyph_code_t GLYPH_SMILEY = 4'd10;
    localparam glyph_code_t GLYPH_BLANK  = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        PENDING = 2'd2
    } state_t;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_digit_renderer_if.sv
// Bus between game logic / video timing (master) and the score renderer
// (slave).
//   score, score_valid : binary score load request (master -> slave)
//   busy               : conversion or pending commit (slave -> master)
//   frame_start        : first-pixel-of-frame pulse (master -> slave)
//   x, y               : beam coordinates (master -> slave)
//   pixel_on           : glyph pixel lit, 2 cycles after x/y (slave -> master)
interface score_digit_renderer_if #(
    parameter int SCORE_W = 7,
    parameter int COORD_W = 10
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic               busy;
    logic               frame_start;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pixel_on;

    modport master (
        output score, score_valid, frame_start, x, y,
        input  busy, pixel_on
    );

    modport slave (
        input  score, score_valid, frame_start, x, y,
        output busy, pixel_on
    );
endinterface

// File: rtl/score_digit_renderer_glyph_rom.sv
// Combinational 8x8 glyph ROM.
//   code     : glyph code (0..9 digits, 10 smiley, others blank)
//   row      : glyph row, 0 = top
//   row_bits : row bitmap, bit 7 is the leftmost pixel
// Digit glyphs leave row 7 empty; the smiley uses all eight rows.
module glyph_rom
    import score_render_pkg::*;
(
    input  glyph_code_t code,
    input  logic [2:0]  row,
    output logic [7:0]  row_bits
);

    logic [63:0] glyph;

    // Each glyph is packed top row first: bits [63:56] are row 0.
    always_comb begin
        glyph = 64'h0;
        case (code)
            4'd0:    glyph = 64'h3C666E7666663C00;
            4'd1:    glyph = 64'h1838181818187E00;
            4'd2:    glyph = 64'h3C66060C30607E00;
            4'd3:    glyph = 64'h3C66061C06663C00;
            4'd4:    glyph = 64'h0C1C3C6C7E0C0C00;
            4'd5:    glyph = 64'h7E607C0606663C00;
            4'd6:    glyph = 64'h3C66607C66663C00;
            4'd7:    glyph = 64'h7E660C1818181800;
            4'd8:    glyph = 64'h3C66663C66663C00;
            4'd9:    glyph = 64'h3C66663E06663C00;
            4'd10:   glyph = 64'h7E81A581A599817E;
            default: glyph = 64'h0;
        endcase
    end

    assign row_bits = glyph[{3'd7 - row, 3'b000} +: 8];

endmodule

// File: rtl/score_digit_renderer.sv
// Score digit renderer: converts a binary score to BCD with a sequential
// double-dabble engine, commits the digits to the display only on
// frame_start, and renders them as scaled 8x8 glyphs at a fixed position.
//   clk      : pixel clock
//   reset_n  : asynchronous active-low reset
//   bus      : score load, busy, frame_start, beam x/y, pixel_on
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (the least significant digit is always shown).
module score_digit_renderer
    import score_render_pkg::*;
#(
    parameter int DIGITS     = 2,
    parameter int SCORE_W    = 7,
    parameter int SCALE_LOG2 = 1,
    parameter int COORD_W    = 10,
    parameter int X_POS      = 100,
    parameter int Y_POS      = 16
) (
    input  logic clk,
    input  logic reset_n,
    score_digit_renderer_if.slave bus
);

    localparam int CELL  = 8 << SCALE_LOG2;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    localparam logic [31:0]        OVF_LIMIT = 32'(pow10(DIGITS));
    localparam logic [COORD_W-1:0] X_ORG     = COORD_W'(X_POS);
    localparam logic [COORD_W-1:0] Y_ORG     = COORD_W'(Y_POS);
    // One extra bit so the right/bottom limits cannot wrap.
    localparam logic [COORD_W:0]   X_LO = (COORD_W + 1)'(X_POS);
    localparam logic [COORD_W:0]   X_HI = (COORD_W + 1)'(X_POS + DIGITS * CELL);
    localparam logic [COORD_W:0]   Y_LO = (COORD_W + 1)'(Y_POS);
    localparam logic [COORD_W:0]   Y_HI = (COORD_W + 1)'(Y_POS + CELL);

    // ------------------------------------------------------------------
    // Load / convert / commit FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic [SCORE_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [BCD_W-1:0]    bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    glyph_code_t         disp_q [DIGITS];
    glyph_code_t         disp_d [DIGITS];
    glyph_code_t         commit_codes [DIGITS];

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5)
                                  ? bcd_q[4*gi +: 4] + 4'd3
                                  : bcd_q[4*gi +: 4];
    end

    // Digit 0 (leftmost) is the most significant BCD nibble.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic [3:0] nib;
        logic       lead;
        nib  = '0;
        lead = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            nib = bcd_q[4*(DIGITS-1-d) +: 4];
            if (ovf_q) begin
                commit_codes[d] = GLYPH_SMILEY;
            end else if (lead && (nib == 4'd0) && (d < DIGITS - 1)) begin
                commit_codes[d] = GLYPH_BLANK;
            end else begin
                commit_codes[d] = nib;
                lead            = 1'b0;
            end
        end
    end
`else
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            commit_codes[d] = ovf_q ? GLYPH_SMILEY : bcd_q[4*(DIGITS-1-d) +: 4];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (bus.score_valid) begin
                    bin_d   = bus.score;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(SCORE_W);
                    // Overflow is judged on the binary value, so truncated
                    // BCD garbage for large scores never reaches the display.
                    ovf_d   = (32'(bus.score) >= OVF_LIMIT);
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_d = {bin_q[SCORE_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (bus.frame_start) begin
                    disp_d  = commit_codes;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 = geometry + digit select, stage 2 = ROM bit
    // ------------------------------------------------------------------
    logic               hit_d, hit1_q;
    glyph_code_t        code_d, code1_q;
    logic [2:0]         row_d, row1_q;
    logic [2:0]         col_d, col1_q;
    logic [COORD_W-1:0] dx, dy, digit_idx;
    logic [7:0]         rom_row;
    logic               pixel_on_d, pixel_on_q;

    always_comb begin
        hit_d = ({1'b0, bus.x} >= X_LO) && ({1'b0, bus.x} < X_HI) &&
                ({1'b0, bus.y} >= Y_LO) && ({1'b0, bus.y} < Y_HI);
        dx        = bus.x - X_ORG;
        dy        = bus.y - Y_ORG;
        digit_idx = dx >> (3 + SCALE_LOG2);
        col_d     = 3'(dx >> SCALE_LOG2);
        row_d     = 3'(dy >> SCALE_LOG2);
        code_d    = GLYPH_BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == COORD_W'(i)) begin
                code_d = disp_q[i];
            end
        end
    end

    glyph_rom u_glyph_rom (
        .code     (code1_q),
        .row      (row1_q),
        .row_bits (rom_row)
    );

    assign pixel_on_d = hit1_q & rom_row[3'd7 - col1_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit1_q     <= 1'b0;
            code1_q    <= GLYPH_BLANK;
            row1_q     <= '0;
            col1_q     <= '0;
            pixel_on_q <= 1'b0;
        end else begin
            hit1_q     <= hit_d;
            code1_q    <= code_d;
            row1_q     <= row_d;
            col1_q     <= col_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.pixel_on = pixel_on_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Directed self-checking bench for score_digit_renderer
// (DIGITS=2, SCORE_W=7, SCALE_LOG2=1, box x 100..131, y 16..31).
module tb_score_digit_renderer;

    localparam int DIGITS = 2;
    localparam int SCORE_W = 7;
    localparam int SCALE_LOG2 = 1;
    localparam int COORD_W = 10;
    localparam int X_POS = 100;
    localparam int Y_POS = 16;
    localparam int CELL = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    score_digit_renderer_if #(.SCORE_W(SCORE_W), .COORD_W(COORD_W)) bus ();

    score_digit_renderer #(
        .DIGITS(DIGITS), .SCORE_W(SCORE_W), .SCALE_LOG2(SCALE_LOG2),
        .COORD_W(COORD_W), .X_POS(X_POS), .Y_POS(Y_POS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    function automatic logic [63:0] font(input logic [3:0] c);
        case (c)
            4'd0:    return 64'h3C666E7666663C00;
            4'd1:    return 64'h1838181818187E00;
            4'd2:    return 64'h3C66060C30607E00;
            4'd3:    return 64'h3C66061C06663C00;
            4'd4:    return 64'h0C1C3C6C7E0C0C00;
            4'd5:    return 64'h7E607C0606663C00;
            4'd6:    return 64'h3C66607C66663C00;
            4'd7:    return 64'h7E660C1818181800;
            4'd8:    return 64'h3C66663C66663C00;
            4'd9:    return 64'h3C66663E06663C00;
            4'd10:   return 64'h7E81A581A599817E;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic exp_pixel(input int xx, input int yy,
                                       input logic [3:0] c0, input logic [3:0] c1);
        logic [63:0] g;
        int dx, dy, col, row;
        if (xx < X_POS || xx >= X_POS + DIGITS * CELL || yy < Y_POS || yy >= Y_POS + CELL)
            return 1'b0;
        dx  = xx - X_POS;
        dy  = yy - Y_POS;
        col = (dx / 2) % 8;
        row = (dy / 2) % 8;
        g   = font((dx / CELL) == 0 ? c0 : c1);
        return g[8 * (7 - row) + (7 - col)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_xy(input int xx, input int yy);
        bus.x = COORD_W'(xx);
        bus.y = COORD_W'(yy);
    endtask

    // Streams every pixel of the box plus a one-pixel margin, one per cycle,
    // and checks pixel_on two cycles after each coordinate is presented.
    task automatic scan(input string tag, input logic [3:0] c0, input logic [3:0] c1);
        logic     expq[$];
        int       xq[$];
        int       yq[$];
        int       errs_before;
        errs_before = bad;
        for (int yy = Y_POS - 1; yy <= Y_POS + CELL; yy++) begin
            for (int xx = X_POS - 1; xx <= X_POS + DIGITS * CELL; xx++) begin
                set_xy(xx, yy);
                expq.push_back(exp_pixel(xx, yy, c0, c1));
                xq.push_back(xx);
                yq.push_back(yy);
                tick();
                if (expq.size() == 2)
                    chk($sformatf("%s pix(%0d,%0d)", tag, xq.pop_front(), yq.pop_front()),
                        32'(bus.pixel_on), 32'(expq.pop_front()));
            end
        end
        set_xy(0, 0);
        tick();
        while (expq.size() > 0)
            chk($sformatf("%s pix(%0d,%0d)", tag, xq.pop_front(), yq.pop_front()),
                32'(bus.pixel_on), 32'(expq.pop_front()));
        $display("scan %s codes=%0d,%0d errors=%0d", tag, c0, c1, bad - errs_before);
    endtask

    // Leaves the bench one cycle after the load edge (FSM in CONVERT).
    task automatic load(input int val);
        bus.score       = SCORE_W'(val);
        bus.score_valid = 1'b1;
        tick();
        bus.score_valid = 1'b0;
        $display("load score=%0d busy=%0b", val, bus.busy);
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        $display("frame_start busy=%0b", bus.busy);
    endtask

    // Sample a single pixel through the 2-cycle pipeline.
    task automatic pix(input string tag, input int xx, input int yy, input logic expv);
        set_xy(xx, yy);
        tick();
        tick();
        chk(tag, 32'(bus.pixel_on), 32'(expv));
        $display("pix %s (%0d,%0d) -> %0b", tag, xx, yy, bus.pixel_on);
    endtask

    logic [3:0] lead_code;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        lead_code = 4'd15;
`else
        lead_code = 4'd0;
`endif
        bus.score = '0;
        bus.score_valid = 1'b0;
        bus.frame_start = 1'b0;
        set_xy(X_POS + 4, Y_POS);

        // Reset state
        tick();
        tick();
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst pixel_on", 32'(bus.pixel_on), 32'd0);
        reset_n = 1'b1;
        tick();
        scan("reset", lead_code, 4'd0);
        chk("idle busy", 32'(bus.busy), 32'd0);

        // Score 42, frame_start 20 cycles after the load
        load(42);
        chk("42 busy after load", 32'(bus.busy), 32'd1);
        for (int i = 1; i < 20; i++) begin
            if (i == 7) chk("42 busy at 7", 32'(bus.busy), 32'd1);
            tick();
        end
        chk("42 busy before frame", 32'(bus.busy), 32'd1);
        pulse_frame();
        chk("42 busy after commit", 32'(bus.busy), 32'd0);
        pix("42 g4 r0 c1", X_POS + 2, Y_POS, 1'b0);
        pix("42 g4 r0 c4", X_POS + 8, Y_POS, 1'b1);
        scan("42", 4'd4, 4'd2);
        // frame_start while idle changes nothing
        pulse_frame();
        chk("idle frame busy", 32'(bus.busy), 32'd0);
        pix("idle frame g4 r0 c4", X_POS + 8, Y_POS, 1'b1);

        // Overflow -> smiley in both cells
        load(100);
        repeat (10) tick();
        pulse_frame();
        pix("smiley r7 c1", X_POS + 2, Y_POS + 14, 1'b1);
        pix("smiley d1 r7 c0", X_POS + 16, Y_POS + 15, 1'b0);
        scan("100", 4'd10, 4'd10);

        // Second load during CONVERT is ignored
        load(55);
        tick();
        tick();
        bus.score = 7'd7;
        bus.score_valid = 1'b1;
        tick();
        bus.score_valid = 1'b0;
        repeat (8) tick();
        pulse_frame();
        chk("55 busy after commit", 32'(bus.busy), 32'd0);
        scan("55 ignore 7", 4'd5, 4'd5);

        // frame_start on the edge that enters PENDING is not taken
        load(63);
        repeat (6) tick();
        pulse_frame();
        chk("63 busy after early frame", 32'(bus.busy), 32'd1);
        pix("63 old d1 r0 c0", X_POS + 16, Y_POS, 1'b0);
        pix("63 old d0 r1 c1", X_POS + 2, Y_POS + 2, 1'b1);
        pix("63 old d0 r2 c6", X_POS + 12, Y_POS + 4, 1'b0);
        repeat (3) tick();
        chk("63 busy still pending", 32'(bus.busy), 32'd1);
        pulse_frame();
        chk("63 busy after commit", 32'(bus.busy), 32'd0);
        scan("63", 4'd6, 4'd3);

        // Reset in the middle of CONVERT
        pix("pre-reset lit", X_POS + 4, Y_POS, 1'b1);
        load(99);
        tick();
        chk("99 busy mid convert", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid reset busy", 32'(bus.busy), 32'd0);
        chk("mid reset pixel_on", 32'(bus.pixel_on), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        repeat (10) tick();
        pulse_frame();
        chk("post reset busy", 32'(bus.busy), 32'd0);
        scan("after reset", lead_code, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
